axi4_lite_master: RTL and testbench

AXI4-Lite initiator that converts a simple single-outstanding command/response interface into AXI4-Lite read and write transactions. It sits between a local controller (test sequencer, CPU-side glue) and any AXI4-Lite register slave in the design. It issues one transaction at a time, holds the slave's response until the controller takes it, and fully tolerates wait states on every channel.

---
 rtl/axi4_lite_pkg.sv | 19 +
 rtl/axi4_lite_master.sv | 147 ++++++++++++++
 tb/tb_axi4_lite_master.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the transaction state encoding
// used by both the initiator and the register slave.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5
    } axi_state_e;

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator: turns one command into one AXI read or
// write, then holds the slave's response until the controller consumes it.
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    CMD_VALID,
    output logic                    CMD_READY,
    input  logic                    CMD_WRITE,
    input  logic [ADDRESS-1:0]      CMD_ADDR,
    input  logic [DATA_WIDTH-1:0]   CMD_WDATA,
    input  logic [DATA_WIDTH/8-1:0] CMD_WSTRB,
    output logic                    RSP_VALID,
    input  logic                    RSP_READY,
    output logic                    RSP_WRITE,
    output logic [DATA_WIDTH-1:0]   RSP_RDATA,
    output logic [1:0]              RSP_RESP,
    output logic [ADDRESS-1:0]      M_AWADDR,
    output logic                    M_AWVALID,
    input  logic                    M_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_WSTRB,
    output logic                    M_WVALID,
    input  logic                    M_WREADY,
    input  logic [1:0]              M_BRESP,
    input  logic                    M_BVALID,
    output logic                    M_BREADY,
    output logic [ADDRESS-1:0]      M_ARADDR,
    output logic                    M_ARVALID,
    input  logic                    M_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_RDATA,
    input  logic [1:0]              M_RRESP,
    input  logic                    M_RVALID,
    output logic                    M_RREADY
);

    localparam logic [ADDRESS-1:0] ALIGN_MASK = ~ADDRESS'(3);

    axi_state_e             state;
    logic                   aw_done, w_done;
    logic [ADDRESS-1:0]     addr_q;
    logic                   aw_fire, w_fire;

    assign aw_fire  = M_AWVALID && M_AWREADY;
    assign w_fire   = M_WVALID && M_WREADY;
    assign M_AWADDR = addr_q;
    assign M_ARADDR = addr_q;

    // Every handshake output is a flop so no slave input reaches a master output
    // combinationally; CMD_READY comes up on the first edge after reset release.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= ST_IDLE;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            addr_q    <= '0;
            M_WDATA   <= '0;
            M_WSTRB   <= '0;
            CMD_READY <= 1'b0;
            M_AWVALID <= 1'b0;
            M_WVALID  <= 1'b0;
            M_BREADY  <= 1'b0;
            M_ARVALID <= 1'b0;
            M_RREADY  <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_WRITE <= 1'b0;
            RSP_RDATA <= '0;
            RSP_RESP  <= RESP_OKAY;
        end else begin
            case (state)
                ST_IDLE: begin
                    CMD_READY <= 1'b1;
                    if (CMD_VALID && CMD_READY) begin
                        CMD_READY <= 1'b0;
                        addr_q    <= CMD_ADDR & ALIGN_MASK;
                        M_WDATA   <= CMD_WDATA;
                        M_WSTRB   <= CMD_WSTRB;
                        if (CMD_WRITE) begin
                            M_AWVALID <= 1'b1;
                            M_WVALID  <= 1'b1;
                            state     <= ST_WR_REQ;
                        end else begin
                            M_ARVALID <= 1'b1;
                            state     <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (aw_fire) begin
                        M_AWVALID <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_fire) begin
                        M_WVALID <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                        M_BREADY <= 1'b1;
                        state    <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (M_BVALID) begin
                        M_BREADY  <= 1'b0;
                        RSP_VALID <= 1'b1;
                        RSP_WRITE <= 1'b1;
                        RSP_RDATA <= '0;
                        RSP_RESP  <= M_BRESP;
                        state     <= ST_RSP;
                    end
                end
                ST_RD_ADDR: begin
                    if (M_ARREADY) begin
                        M_ARVALID <= 1'b0;
                        M_RREADY  <= 1'b1;
                        state     <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (M_RVALID) begin
                        M_RREADY  <= 1'b0;
                        RSP_VALID <= 1'b1;
                        RSP_WRITE <= 1'b0;
                        RSP_RDATA <= M_RDATA;
                        RSP_RESP  <= M_RRESP;
                        state     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        CMD_READY <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master: the bench plays controller and AXI slave
// cycle by cycle, driving and sampling on the falling edge.
module tb_axi4_lite_master;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b1;
    logic        CMD_VALID = 0, CMD_READY, CMD_WRITE = 0;
    logic [31:0] CMD_ADDR = 0, CMD_WDATA = 0;
    logic [3:0]  CMD_WSTRB = 0;
    logic        RSP_VALID, RSP_READY = 0, RSP_WRITE;
    logic [31:0] RSP_RDATA;
    logic [1:0]  RSP_RESP;
    logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA = 0;
    logic        M_AWVALID, M_AWREADY = 0, M_WVALID, M_WREADY = 0;
    logic [3:0]  M_WSTRB;
    logic [1:0]  M_BRESP = 0, M_RRESP = 0;
    logic        M_BVALID = 0, M_BREADY, M_ARVALID, M_ARREADY = 0, M_RVALID = 0, M_RREADY;

    int n_chk = 0;
    int n_fail = 0;

    always #5 ACLK = ~ACLK;

    axi4_lite_master dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_WSTRB(CMD_WSTRB),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_WRITE(RSP_WRITE),
        .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP),
        .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge ACLK);
    endtask

    // Wide OR of every master output, for the "everything is zero" checks.
    function automatic logic any_out();
        return |{CMD_READY, RSP_VALID, RSP_WRITE, RSP_RDATA, RSP_RESP, M_AWADDR, M_AWVALID,
                 M_WDATA, M_WSTRB, M_WVALID, M_BREADY, M_ARADDR, M_ARVALID, M_RREADY};
    endfunction

    task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        CMD_VALID = 1; CMD_WRITE = wr; CMD_ADDR = a; CMD_WDATA = d; CMD_WSTRB = s;
        step();
        CMD_VALID = 0;
    endtask

    initial begin
        #1 ARESETN = 0;
        step();
        chk("reset_outputs_zero", any_out(), 0);
        step();
        ARESETN = 1;
        step();
        chk("post_reset_cmd_ready", CMD_READY, 1);

        // zero-wait write
        send_cmd(1, 32'h0000_000C, 32'hDEAD_BEEF, 4'hF);
        chk("wr_awvalid", M_AWVALID, 1);
        chk("wr_wvalid", M_WVALID, 1);
        chk("wr_awaddr", M_AWADDR, 32'h0C);
        chk("wr_wdata", M_WDATA, 32'hDEAD_BEEF);
        chk("wr_wstrb", M_WSTRB, 4'hF);
        chk("wr_cmd_ready_low", CMD_READY, 0);
        M_AWREADY = 1; M_WREADY = 1;
        step();
        chk("wr_aw_dropped", M_AWVALID, 0);
        chk("wr_w_dropped", M_WVALID, 0);
        chk("wr_bready", M_BREADY, 1);
        chk("wr_no_rsp_yet", RSP_VALID, 0);
        M_AWREADY = 0; M_WREADY = 0; M_BVALID = 1; M_BRESP = 2'b00;
        step();
        chk("wr_rsp_valid", RSP_VALID, 1);
        chk("wr_rsp_write", RSP_WRITE, 1);
        chk("wr_rsp_resp", RSP_RESP, 2'b00);
        chk("wr_rsp_rdata", RSP_RDATA, 0);
        chk("wr_bready_low", M_BREADY, 0);
        M_BVALID = 0; RSP_READY = 1;
        step();
        chk("wr_rsp_cleared", RSP_VALID, 0);
        chk("wr_idle_cmd_ready", CMD_READY, 1);
        RSP_READY = 0;

        // read with ARREADY delayed; unaligned address must come out aligned
        send_cmd(0, 32'h0000_000E, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            chk("rd_arvalid_held", M_ARVALID, 1);
            chk("rd_araddr_held", M_ARADDR, 32'h0C);
            chk("rd_rready_low", M_RREADY, 0);
            if (i == 3) M_ARREADY = 1;
            step();
        end
        chk("rd_ar_dropped", M_ARVALID, 0);
        chk("rd_rready", M_RREADY, 1);
        M_ARREADY = 0; M_RVALID = 1; M_RDATA = 32'hDEAD_BEEF; M_RRESP = 2'b00;
        step();
        chk("rd_rsp_valid", RSP_VALID, 1);
        chk("rd_rsp_rdata", RSP_RDATA, 32'hDEAD_BEEF);
        chk("rd_rsp_resp", RSP_RESP, 2'b00);
        chk("rd_rsp_write", RSP_WRITE, 0);
        chk("rd_rready_low_after", M_RREADY, 0);
        M_RVALID = 0; RSP_READY = 1;
        step();
        chk("rd_rsp_cleared", RSP_VALID, 0);
        RSP_READY = 0;

        // W accepted two cycles before AW; DECERR passes through
        send_cmd(1, 32'h0000_0010, 32'h1234_5678, 4'h3);
        M_WREADY = 1;
        step();
        chk("split_w_dropped", M_WVALID, 0);
        chk("split_aw_held", M_AWVALID, 1);
        chk("split_no_bready", M_BREADY, 0);
        M_WREADY = 0;
        step();
        chk("split_aw_still_held", M_AWVALID, 1);
        chk("split_awaddr", M_AWADDR, 32'h10);
        chk("split_no_bready2", M_BREADY, 0);
        M_AWREADY = 1;
        step();
        chk("split_aw_dropped", M_AWVALID, 0);
        chk("split_bready", M_BREADY, 1);
        M_AWREADY = 0; M_BVALID = 1; M_BRESP = 2'b11;
        step();
        chk("split_rsp_resp", RSP_RESP, 2'b11);
        chk("split_rsp_write", RSP_WRITE, 1);
        M_BVALID = 0; M_BRESP = 0; RSP_READY = 1;
        step();
        RSP_READY = 0;

        // SLVERR read, then response stalled while CMD_VALID toggles
        send_cmd(0, 32'h0000_0020, 32'h0, 4'h0);
        M_ARREADY = 1;
        step();
        M_ARREADY = 0; M_RVALID = 1; M_RDATA = 32'h0000_1234; M_RRESP = 2'b10;
        step();
        M_RVALID = 0; M_RDATA = 0; M_RRESP = 0;
        CMD_WRITE = 1; CMD_ADDR = 32'h40;
        for (int i = 0; i < 5; i++) begin
            CMD_VALID = (i % 2 == 0);
            chk("stall_rsp_valid", RSP_VALID, 1);
            chk("stall_rsp_resp", RSP_RESP, 2'b10);
            chk("stall_rsp_rdata", RSP_RDATA, 32'h1234);
            chk("stall_cmd_ready", CMD_READY, 0);
            chk("stall_no_aw_ar", {M_AWVALID, M_ARVALID}, 0);
            step();
        end
        CMD_VALID = 0; RSP_READY = 1;
        step();
        chk("stall_released", RSP_VALID, 0);
        chk("stall_idle", CMD_READY, 1);
        chk("stall_no_aw_after", M_AWVALID, 0);
        RSP_READY = 0;

        // reset while waiting for B
        send_cmd(1, 32'h0000_0030, 32'hCAFE_F00D, 4'hF);
        M_AWREADY = 1; M_WREADY = 1;
        step();
        M_AWREADY = 0; M_WREADY = 0;
        chk("rst_in_wr_resp", M_BREADY, 1);
        #2 ARESETN = 0;
        #1 chk("rst_async_outputs_zero", any_out(), 0);
        step();
        M_BVALID = 1;
        step();
        M_BVALID = 0;
        ARESETN = 1;
        step();
        chk("rst_release_cmd_ready", CMD_READY, 1);
        chk("rst_release_no_rsp", RSP_VALID, 0);
        chk("rst_release_no_bready", M_BREADY, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end

endmodule
